pulse_generator: RTL

- Programmable square-wave source: drives a pulse train with a cycle-exact period and high time, both counted in MAX10_CLK1_50 cycles.
- It is the stimulus end of the frequency-measurement path. Its pulse_out feeds the frequency detector's pulse input, so the board can measure itself (loopback) with known values.
- Configuration comes from switches or a controller. New values are double-buffered and take effect only at a period boundary, so the output never shows a glitched period.

---
 rtl/freq_pkg.sv | 12 +
 rtl/pulse_gen_cfg.sv | 66 ++++++
 rtl/pulse_generator.sv | 105 ++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// Shared constants and types for the pulse generator / frequency detector pair.
package freq_pkg;
  localparam int CNT_W_DEF  = 26;
  localparam int PCNT_W_DEF = 16;
  localparam int CLK_HZ     = 50_000_000;
  localparam int MIN_PERIOD = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;
endpackage

// File: rtl/pulse_gen_cfg.sv
// Double-buffered period/high-time configuration with load validation and
// high-time saturation; pending values move to active only when told to.
module pulse_gen_cfg
  import freq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             MAX10_CLK1_50,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] period_cycles,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic             load,
  input  logic             advance,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] act_high,
  output logic [CNT_W-1:0] nxt_high,
  output logic             pend_valid,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(MIN_PERIOD);

  logic [CNT_W-1:0] pend_period;
  logic [CNT_W-1:0] pend_high;
  logic             load_ok;

  // Clamp so every period keeps at least one low cycle.
  function automatic logic [CNT_W-1:0] sat_high(input logic [CNT_W-1:0] p,
                                                input logic [CNT_W-1:0] h);
    return (h >= p) ? (p - ONE) : h;
  endfunction

  assign load_ok  = (period_cycles >= MIN_PER);
  assign nxt_high = pend_valid ? pend_high : act_high;

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      pend_period <= '0;
      pend_high   <= '0;
      act_period  <= '0;
      act_high    <= '0;
      pend_valid  <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      // The advance uses what was pending before this edge; a load on the
      // same edge refills the buffer for the following boundary.
      if (advance && pend_valid) begin
        act_period <= pend_period;
        act_high   <= pend_high;
        pend_valid <= 1'b0;
      end
      if (load) begin
        if (load_ok) begin
          pend_period <= period_cycles;
          pend_high   <= sat_high(period_cycles, high_cycles);
          pend_valid  <= 1'b1;
          cfg_err     <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pulse_generator.sv
// Programmable square-wave source with cycle-exact period and high time;
// configuration changes land only on period boundaries.
module pulse_generator
  import freq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PCNT_W = PCNT_W_DEF
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset_n,
  input  logic [CNT_W-1:0]  period_cycles,
  input  logic [CNT_W-1:0]  high_cycles,
  input  logic              load,
  input  logic              enable,
  output logic              pulse_out,
  output logic              period_start,
  output logic              active,
  output logic              cfg_err,
  output logic [PCNT_W-1:0] period_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  run_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_high;
  logic [CNT_W-1:0] nxt_high;
  logic             pend_valid;
  logic             boundary;
  logic             start;
  logic             advance;
  logic             nxt_has_high;

  assign cnt_inc      = cnt + ONE;
  assign boundary     = (state == RUN) && (cnt == (act_period - ONE));
  assign start        = (state == IDLE) && enable && pend_valid;
  assign advance      = start || (boundary && enable);
  assign nxt_has_high = (nxt_high != '0);

  pulse_gen_cfg #(
    .CNT_W(CNT_W)
  ) u_cfg (
    .MAX10_CLK1_50(MAX10_CLK1_50),
    .reset_n      (reset_n),
    .period_cycles(period_cycles),
    .high_cycles  (high_cycles),
    .load         (load),
    .advance      (advance),
    .act_period   (act_period),
    .act_high     (act_high),
    .nxt_high     (nxt_high),
    .pend_valid   (pend_valid),
    .cfg_err      (cfg_err)
  );

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pulse_out    <= 1'b0;
      period_start <= 1'b0;
      active       <= 1'b0;
      period_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          pulse_out    <= 1'b0;
          period_start <= 1'b0;
          active       <= 1'b0;
          if (start) begin
            state        <= RUN;
            cnt          <= '0;
            pulse_out    <= nxt_has_high;
            period_start <= nxt_has_high;
            active       <= 1'b1;
          end
        end
        RUN: begin
          if (boundary) begin
            cnt          <= '0;
            period_count <= period_count + PCNT_W'(1);
            if (enable) begin
              pulse_out    <= nxt_has_high;
              period_start <= nxt_has_high;
            end else begin
              // Enable dropped: this period has completed, park in IDLE.
              state        <= IDLE;
              pulse_out    <= 1'b0;
              period_start <= 1'b0;
              active       <= 1'b0;
            end
          end else begin
            cnt          <= cnt_inc;
            pulse_out    <= (cnt_inc < act_high);
            period_start <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
